// File: rtl/switch_debounce_vector.sv
// Per-channel switch debouncer: two-flop synchroniser, mismatch counter and registered vector.
// Also keeps a rising-edge toggle register, and the LED mux selects between vector and toggle.
module switch_debounce_vector #(
    parameter int WIDTH    = 6,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch,
    input  logic             mode,
    output logic [WIDTH-1:0] vector,
    output logic [WIDTH-1:0] led,
    output logic             changed
);

    localparam int            CW      = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] vector_q;
    logic [WIDTH-1:0] vector_d;
    logic [WIDTH-1:0] toggle_q;
    logic [WIDTH-1:0] toggle_d;
    logic             changed_q;
    logic             changed_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // A channel is accepted on the edge where its counter is already at the
    // limit; with DEBOUNCE=1 the limit is 0, so the first mismatch is taken.
    always_comb begin
        vector_d = vector_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != vector_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    vector_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        changed_d = |(vector_d ^ vector_q);
        toggle_d  = toggle_q ^ (vector_d & ~vector_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= '0;
            s2_q      <= '0;
            vector_q  <= '0;
            toggle_q  <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= switch;
            s2_q      <= s1_q;
            vector_q  <= vector_d;
            toggle_q  <= toggle_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign vector  = vector_q;
    assign changed = changed_q;
    assign led     = mode ? toggle_q : vector_q;

endmodule

// File: doc/switch_debounce_vector.md
SWITCH_DEBOUNCE_VECTOR -- requirements
Module: switch_debounce_vector

Interface
REQ-001 SHALL have parameter WIDTH, default 6: number of switch channels and LED bits (1..32).
REQ-002 SHALL have parameter DEBOUNCE, default 4: consecutive clock cycles a synchronised input must differ before it is accepted (1..65535).
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port switch  input  WIDTH: raw asynchronous switch levels; bit i is channel i.
REQ-006 SHALL have port mode  input  1: LED source select; 0 = direct, 1 = toggle.
REQ-007 SHALL have port vector  output  WIDTH: debounced switch vector, registered.
REQ-008 SHALL have port led  output  WIDTH: LED drive, selected by mode.
REQ-009 SHALL have port changed  output  1: one-cycle pulse when vector changes, registered.

Function
REQ-010 SHALL pass each switch bit through a two-flop synchroniser (s1, s2) before any other use.
REQ-011 SHALL keep one counter per channel, width clog2(DEBOUNCE+1); the counter never exceeds DEBOUNCE-1.
REQ-012 SHALL, per channel, on each edge where s2[i] == vector[i], clear counter i.
REQ-013 SHALL, per channel, on each edge where s2[i] != vector[i] and counter i < DEBOUNCE-1, increment counter i.
REQ-014 SHALL, per channel, on the edge where s2[i] != vector[i] and counter i == DEBOUNCE-1, load vector[i] <= s2[i] and clear counter i.
REQ-015 SHALL give this latency: for a clean switch change first sampled at edge E, vector updates at edge E+DEBOUNCE+1; e.g. DEBOUNCE=4, E=1 gives edge 6.
REQ-016 SHALL reject glitches: a mismatch lasting fewer than DEBOUNCE consecutive s2 cycles leaves vector unchanged and clears the counter.
REQ-017 SHALL run all channels independently; channels may update on the same edge.
REQ-018 SHALL set changed to 1 on any edge where at least one vector bit changes, and to 0 otherwise; simultaneous channel changes give a single one-cycle pulse.
REQ-019 SHALL keep a WIDTH-bit toggle register; bit i inverts on the same edge that vector[i] goes 0->1. A 1->0 change of vector[i] does not affect it.
REQ-020 SHALL update the toggle register regardless of mode.
REQ-021 SHALL drive led = vector when mode=0 and led = toggle register when mode=1, through a combinational mux; a mode change takes effect in the same cycle with no state change.
REQ-022 SHALL, when DEBOUNCE=1, accept a mismatch on the first edge it is seen (counter held at 0).

Reset
REQ-023 SHALL, while rst=1, asynchronously force s1, s2, all counters, vector, toggle register and changed to 0; led is therefore 0 in both modes.
REQ-024 SHALL, on rst asserted mid-count, discard the partial count; after release, a channel requires a full DEBOUNCE count again.
REQ-025 SHALL, on release of rst with switch bits held at 1, treat them as new changes: vector updates at edge DEBOUNCE+2 after release and changed pulses once.

Verification (WIDTH=6, DEBOUNCE=4 unless stated)
REQ-026 SHALL cover: hold switch=6'b101010 through reset, then release -> vector=0, led=0, changed=0 until edge 6; then vector=6'b101010, changed=1 for exactly one cycle; with mode=1, led=6'b101010.
REQ-027 SHALL cover: bit0 pulsed high for 3 cycles, then low -> vector[0] stays 0, changed never asserts, counter 0 returns to 0.
REQ-028 SHALL cover: mode=0, switch counts 0..63 with one step every 100 cycles -> led equals each switch value from 6 edges after the step until the next step; exactly one changed pulse per step.
REQ-029 SHALL cover: mode=1, bit2 press/release twice, each level held 20 cycles -> led[2] goes 0->1 on the first press, stays 1 on release, goes 1->0 on the second press; other led bits stay 0; switching mode to 0 shows vector immediately.
REQ-030 SHALL cover: bit5 raised, then rst asserted when counter 5 == 2 -> all outputs 0 immediately; after release with bit5 still high, vector[5]=1 at edge 6 after release.
REQ-031 SHALL cover: DEBOUNCE=1 instance, bit1 raised -> vector[1]=1 at edge 3 after first sampling; a 1-cycle glitch after synchronisation is accepted.
